// File: rtl/alu_sequencer.sv
// Four-state (IDLE/READ/EXEC/WB) controller that sequences a 16-bit ALU and register file.
// Optional immediate forms (ADDI/MOVI) are enabled by defining ALU_SEQ_IMM_EN.
module alu_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RA_W  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  output logic [RA_W-1:0]  rf_raddr1,
  output logic [RA_W-1:0]  rf_raddr2,
  input  logic [WIDTH-1:0] rf_rdata1,
  input  logic [WIDTH-1:0] rf_rdata2,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             rf_we,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alucont,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [5:0]       alu_psr,
  output logic [4:0]       psr,
  output logic             done,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_CMP  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
`ifdef ALU_SEQ_IMM_EN
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_MOVI = 4'h9;
`endif

  // psr bit order: {N,Z,L,F,C}
  localparam logic [4:0] MASK_ADD   = 5'b11011;
  localparam logic [4:0] MASK_SUB   = 5'b11111;
  localparam logic [4:0] MASK_LOGIC = 5'b11000;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  state_e           state_q;
  logic [15:0]      ir_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [4:0]       psr_q;
  logic [2:0]       alucont_q;
  logic             ready_q, we_q, done_q, illegal_q;

  logic [3:0]       op_c;
  logic             legal_c, wr_c, bypass_c, imm_b_c;
  logic [2:0]       alu_op_c;
  logic [4:0]       flag_mask_c;
  logic [WIDTH-1:0] imm_val_c;
  logic [WIDTH-1:0] b_d, res_d;
  logic [4:0]       psr_d;
  logic             unused_bits;

  assign op_c = ir_q[15:12];

  // Opcode decode: legality, write-back, ALU function, flag update mask, B substitution
  always_comb begin
    legal_c     = 1'b1;
    wr_c        = 1'b1;
    bypass_c    = 1'b0;
    imm_b_c     = 1'b0;
    alu_op_c    = 3'b000;
    flag_mask_c = 5'b00000;
    imm_val_c   = '0;
    case (op_c)
      OP_ADD: flag_mask_c = MASK_ADD;
      OP_SUB: begin alu_op_c = 3'b001; flag_mask_c = MASK_SUB; end
      OP_CMP: begin alu_op_c = 3'b001; flag_mask_c = MASK_SUB; wr_c = 1'b0; end
      OP_AND: begin alu_op_c = 3'b010; flag_mask_c = MASK_LOGIC; end
      OP_XOR: begin alu_op_c = 3'b011; flag_mask_c = MASK_LOGIC; end
      OP_OR:  begin alu_op_c = 3'b100; flag_mask_c = MASK_LOGIC; end
      OP_MOV: bypass_c = 1'b1;
`ifdef ALU_SEQ_IMM_EN
      OP_ADDI: begin
        imm_b_c     = 1'b1;
        imm_val_c   = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
        flag_mask_c = MASK_ADD;
      end
      OP_MOVI: begin
        imm_b_c   = 1'b1;
        imm_val_c = WIDTH'(ir_q[7:0]);
        bypass_c  = 1'b1;
      end
`endif
      default: begin legal_c = 1'b0; wr_c = 1'b0; end
    endcase
  end

  assign b_d   = imm_b_c ? imm_val_c : rf_rdata2;
  assign res_d = bypass_c ? b_q : alu_result;
  assign psr_d = (psr_q & ~flag_mask_c) | (alu_psr[4:0] & flag_mask_c);

  // Sequencer state and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      psr_q     <= '0;
      alucont_q <= 3'b000;
      ready_q   <= 1'b1;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            ir_q    <= instr;
            ready_q <= 1'b0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          a_q       <= rf_rdata1;
          b_q       <= b_d;
          alucont_q <= alu_op_c;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          if (legal_c) res_q <= res_d;
          psr_q     <= psr_d;
          alucont_q <= 3'b000;
          we_q      <= wr_c;
          done_q    <= 1'b1;
          illegal_q <= ~legal_c;
          state_q   <= S_WB;
        end
        S_WB: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign rf_raddr1   = RA_W'(ir_q[11:8]);
  assign rf_raddr2   = RA_W'(ir_q[3:0]);
  assign rf_waddr    = RA_W'(ir_q[11:8]);
  assign rf_wdata    = res_q;
  assign rf_we       = we_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alucont     = alucont_q;
  assign psr         = psr_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

  // Spare flag bit and imm high nibble are not consumed in every build
  assign unused_bits = ^{alu_psr[5], ir_q[7:4]};

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: behavioural register file and ALU around the DUT,
// with hand-computed expectations for each instruction and timing scenario.
module tb_alu_sequencer;

  logic        clk;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [15:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alucont;
  logic [5:0]  alu_psr;
  logic [4:0]  psr;
  logic        done, illegal;

  int total = 0;
  int bad   = 0;
  int we_cnt;
  int done_cnt;

  logic [15:0] rf [16];
  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [15:0] pre_val;

  alu_sequencer #(.WIDTH(16), .RA_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .alu_a(alu_a), .alu_b(alu_b), .alucont(alucont),
    .alu_result(alu_result), .alu_psr(alu_psr),
    .psr(psr), .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: preload port for the bench, write port for the DUT
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_val;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (rf_we) we_cnt <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // ALU model; C/F/L on logic ops and L on add are deliberately 1 so masking is observable
  always_comb begin
    logic [16:0] sum;
    logic        c, f, l;
    sum = '0;
    c = 1'b0; f = 1'b0; l = 1'b0;
    alu_result = '0;
    case (alucont)
      3'b000: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[15:0];
        c = sum[16];
        f = (alu_a[15] == alu_b[15]) && (alu_result[15] != alu_a[15]);
        l = 1'b1;
      end
      3'b001: begin
        alu_result = alu_a - alu_b;
        c = alu_a < alu_b;
        f = (alu_a[15] != alu_b[15]) && (alu_result[15] != alu_a[15]);
        l = $signed(alu_a) < $signed(alu_b);
      end
      3'b010: begin alu_result = alu_a & alu_b; c = 1'b1; f = 1'b1; l = 1'b1; end
      3'b011: begin alu_result = alu_a ^ alu_b; c = 1'b1; f = 1'b1; l = 1'b1; end
      3'b100: begin alu_result = alu_a | alu_b; c = 1'b1; f = 1'b1; l = 1'b1; end
      default: alu_result = '0;
    endcase
    alu_psr = {1'b1, alu_result[15], (alu_result == 16'h0), l, f, c};
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] addr, input logic [15:0] val);
    pre_we = 1'b1; pre_addr = addr; pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (instr_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (instr_ready !== 1'b1) chk({tag, "_ready_timeout"}, 16'(instr_ready), 16'd1);
  endtask

  // Issue one instruction and check READ, EXEC, WB and the following IDLE cycle
  task automatic run(input string tag, input logic [15:0] ins,
                     input logic [15:0] ea, input logic [15:0] eb, input logic [2:0] eac,
                     input logic ewe, input logic [15:0] ewd, input logic [4:0] epsr,
                     input logic eill);
    wait_ready(tag);
    instr = ins; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, "_rd_ready"}, 16'(instr_ready), 16'd0);
    chk({tag, "_raddr1"}, 16'(rf_raddr1), 16'(ins[11:8]));
    chk({tag, "_raddr2"}, 16'(rf_raddr2), 16'(ins[3:0]));
    @(negedge clk);
    chk({tag, "_ex_ready"}, 16'(instr_ready), 16'd0);
    chk({tag, "_alu_a"}, alu_a, ea);
    chk({tag, "_alu_b"}, alu_b, eb);
    chk({tag, "_alucont"}, 16'(alucont), 16'(eac));
    @(negedge clk);
    chk({tag, "_wb_ready"}, 16'(instr_ready), 16'd0);
    chk({tag, "_we"}, 16'(rf_we), 16'(ewe));
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_illegal"}, 16'(illegal), 16'(eill));
    chk({tag, "_psr"}, 16'(psr), 16'(epsr));
    if (ewe) begin
      chk({tag, "_waddr"}, 16'(rf_waddr), 16'(ins[11:8]));
      chk({tag, "_wdata"}, rf_wdata, ewd);
    end
    @(negedge clk);
    chk({tag, "_idle_ready"}, 16'(instr_ready), 16'd1);
    chk({tag, "_idle_done"}, 16'(done), 16'd0);
    chk({tag, "_idle_we"}, 16'(rf_we), 16'd0);
  endtask

  initial begin
    int w0, d0;
    reset_n = 1'b0; instr_valid = 1'b0; instr = '0;
    pre_we = 1'b0; pre_addr = '0; pre_val = '0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) preload(4'(i), 16'h0000);
    preload(4'd1, 16'd5);
    preload(4'd2, 16'd3);
    preload(4'd3, 16'h7FFF);
    preload(4'd4, 16'd1);
    preload(4'd5, 16'd2);
    preload(4'd6, 16'd2);
    preload(4'd8, 16'd1);

    chk("rst_ready", 16'(instr_ready), 16'd1);
    chk("rst_psr", 16'(psr), 16'd0);
    chk("rst_we", 16'(rf_we), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_illegal", 16'(illegal), 16'd0);
    chk("rst_raddr1", 16'(rf_raddr1), 16'd0);
    chk("rst_waddr", 16'(rf_waddr), 16'd0);
    chk("rst_wdata", rf_wdata, 16'd0);
    chk("rst_alucont", 16'(alucont), 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run("add1",  16'h0102, 16'd5,    16'd3, 3'b000, 1'b1, 16'd8,    5'h00, 1'b0);
    run("add_ov",16'h0304, 16'h7FFF, 16'd1, 3'b000, 1'b1, 16'h8000, 5'h12, 1'b0);
    run("cmp",   16'h2506, 16'd2,    16'd2, 3'b001, 1'b0, 16'h0000, 5'h08, 1'b0);
    run("mov",   16'h6705, 16'd0,    16'd2, 3'b000, 1'b1, 16'd2,    5'h08, 1'b0);
    run("ill",   16'hF000, 16'd0,    16'd0, 3'b000, 1'b0, 16'h0000, 5'h08, 1'b1);
`ifdef ALU_SEQ_IMM_EN
    run("addi",  16'h88FF, 16'd1, 16'hFFFF, 3'b000, 1'b1, 16'h0000, 5'h09, 1'b0);
`else
    run("addi",  16'h88FF, 16'd1, 16'd0,    3'b000, 1'b0, 16'h0000, 5'h08, 1'b1);
`endif
    run("sub",   16'h1201, 16'd3,    16'd8, 3'b001, 1'b1, 16'hFFFB, 5'h15, 1'b0);
    run("and",   16'h3304, 16'h8000, 16'd1, 3'b010, 1'b1, 16'h0000, 5'h0D, 1'b0);
    run("xor",   16'h4201, 16'hFFFB, 16'd8, 3'b011, 1'b1, 16'hFFF3, 5'h15, 1'b0);
    run("or",    16'h5504, 16'd2,    16'd1, 3'b100, 1'b1, 16'd3,    5'h05, 1'b0);

    chk("rf1", rf[1], 16'd8);
    chk("rf3", rf[3], 16'h0000);
    chk("rf7", rf[7], 16'd2);
`ifdef ALU_SEQ_IMM_EN
    chk("rf8", rf[8], 16'h0000);
`else
    chk("rf8", rf[8], 16'd1);
`endif

    // Back-to-back with instr_valid held: MOV chain including a RAW dependency on R10
    wait_ready("b2b");
    instr = 16'h6A01; instr_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_done_%0d", k), 16'(done), 16'(k % 4 == 3));
      chk($sformatf("b2b_ready_%0d", k), 16'(instr_ready), 16'(k % 4 == 0));
      if (k == 3)  chk("b2b_wdata_3", rf_wdata, 16'd8);
      if (k == 7)  chk("b2b_wdata_7", rf_wdata, 16'hFFF3);
      if (k == 11) chk("b2b_wdata_11", rf_wdata, 16'd8);
      if (k == 4)  instr = 16'h6B02;
      if (k == 8)  instr = 16'h6C0A;
      if (k == 12) instr_valid = 1'b0;
    end
    chk("rf12_raw", rf[12], 16'd8);

    // Reset pulsed during EXEC aborts the instruction
    wait_ready("rst_mid");
    w0 = we_cnt; d0 = done_cnt;
    instr = 16'h0102; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 16'(instr_ready), 16'd1);
    chk("abort_psr", 16'(psr), 16'd0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("abort_we_cnt", 16'(we_cnt - w0), 16'd0);
    chk("abort_done_cnt", 16'(done_cnt - d0), 16'd0);
    chk("abort_rf1", rf[1], 16'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
